// File: rtl/car_pkg.sv
// rtl/car_pkg.sv - shared state and sensor-pair codes for the car detector
package car_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6,
    ERR  = 3'd7
  } car_state_t;

  // Sensor-pair codes, bit 1 = outer beam A, bit 0 = inner beam B
  localparam logic [1:0] NONE   = 2'b00;
  localparam logic [1:0] A_ONLY = 2'b10;
  localparam logic [1:0] B_ONLY = 2'b01;
  localparam logic [1:0] BOTH   = 2'b11;

endpackage

// File: rtl/car_detector_if.sv
// rtl/car_detector_if.sv - raw sensor inputs and passage event outputs
interface car_detector_if;
  logic sensor_a;
  logic sensor_b;
  logic car_enter;
  logic car_exit;
  logic seq_error;
  logic busy;

  modport master (
    output sensor_a, sensor_b,
    input  car_enter, car_exit, seq_error, busy
  );

  modport slave (
    input  sensor_a, sensor_b,
    output car_enter, car_exit, seq_error, busy
  );
endinterface

// File: rtl/sensor_debouncer.sv
// rtl/sensor_debouncer.sv - two-flop synchronizer plus consecutive-cycle debouncer
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The accepting edge is the one on which the count would reach DEBOUNCE_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (sync2 != deb) begin
      if (cnt == LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/car_detector.sv
// rtl/car_detector.sv - debounced beam pair feeding the passage direction FSM
module car_detector
  import car_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  car_detector_if.slave bus
);

  logic       deb_a;
  logic       deb_b;
  logic [1:0] pair;

  car_state_t state;
  car_state_t next_state;
  logic       enter_next;
  logic       exit_next;
  logic       enter_q;
  logic       exit_q;

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk (clk),
    .rst (rst),
    .raw (bus.sensor_a),
    .deb (deb_a)
  );

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk (clk),
    .rst (rst),
    .raw (bus.sensor_b),
    .deb (deb_b)
  );

  assign pair = {deb_a, deb_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state   <= next_state;
      enter_q <= enter_next;
      exit_q  <= exit_next;
    end
  end

  // Codes not listed for a state hold it; pulses only leave E3/X3 on NONE
  always_comb begin
    next_state = state;
    enter_next = 1'b0;
    exit_next  = 1'b0;
    unique case (state)
      IDLE: begin
        case (pair)
          A_ONLY:  next_state = E1;
          B_ONLY:  next_state = X1;
          BOTH:    next_state = ERR;
          default: next_state = IDLE;
        endcase
      end
      E1: begin
        case (pair)
          BOTH:    next_state = E2;
          NONE:    next_state = IDLE;
          B_ONLY:  next_state = ERR;
          default: next_state = E1;
        endcase
      end
      E2: begin
        case (pair)
          B_ONLY:  next_state = E3;
          A_ONLY:  next_state = E1;
          NONE:    next_state = ERR;
          default: next_state = E2;
        endcase
      end
      E3: begin
        case (pair)
          NONE: begin
            next_state = IDLE;
            enter_next = 1'b1;
          end
          BOTH:    next_state = E2;
          A_ONLY:  next_state = ERR;
          default: next_state = E3;
        endcase
      end
      X1: begin
        case (pair)
          BOTH:    next_state = X2;
          NONE:    next_state = IDLE;
          A_ONLY:  next_state = ERR;
          default: next_state = X1;
        endcase
      end
      X2: begin
        case (pair)
          A_ONLY:  next_state = X3;
          B_ONLY:  next_state = X1;
          NONE:    next_state = ERR;
          default: next_state = X2;
        endcase
      end
      X3: begin
        case (pair)
          NONE: begin
            next_state = IDLE;
            exit_next  = 1'b1;
          end
          BOTH:    next_state = X2;
          B_ONLY:  next_state = ERR;
          default: next_state = X3;
        endcase
      end
      ERR: begin
        if (pair == NONE) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.car_enter = enter_q;
  assign bus.car_exit  = exit_q;
  assign bus.seq_error = (state == ERR);
  assign bus.busy      = (state != IDLE);

endmodule
